// File: rtl/pipeline_pkg.sv
// Shared pipeline definitions: opcodes decoded in fetch and the encoding of
// the 2-bit branch history counters.
// No ports; imported by the predictor, its counter helper and the bench.
package pipeline_pkg;

  localparam logic [5:0] OPC_BEQ = 6'b000100;
  localparam logic [5:0] OPC_J   = 6'b000010;

  // Upper bit of the counter is the taken/not-taken prediction.
  typedef enum logic [1:0] {
    CTR_SNT = 2'b00,
    CTR_WNT = 2'b01,
    CTR_WT  = 2'b10,
    CTR_ST  = 2'b11
  } ctr_e;

endpackage

// File: rtl/branch_predictor_if.sv
// Bundle between the fetch/resolve pipeline and the branch predictor.
//   master : pipeline side, drives fetch PC/instruction and branch resolution.
//   slave  : predictor side, returns prediction, mispredict flag and statistics.
interface branch_predictor_if #(
  parameter int STAT_BITS = 16
);

  logic [31:0]          if_pc;
  logic [31:0]          if_ins;
  logic                 predict_taken;
  logic [31:0]          predict_target;
  logic                 upd_valid;
  logic [31:0]          upd_pc;
  logic                 upd_taken;
  logic [31:0]          upd_target;
  logic                 upd_predicted;
  logic                 mispredict;
  logic [STAT_BITS-1:0] stat_branches;
  logic [STAT_BITS-1:0] stat_mispredict;

  modport master (
    output if_pc, if_ins, upd_valid, upd_pc, upd_taken, upd_target, upd_predicted,
    input  predict_taken, predict_target, mispredict, stat_branches, stat_mispredict
  );

  modport slave (
    input  if_pc, if_ins, upd_valid, upd_pc, upd_taken, upd_target, upd_predicted,
    output predict_taken, predict_target, mispredict, stat_branches, stat_mispredict
  );

endinterface

// File: rtl/branch_predictor_sat_counter2.sv
// Next-state function of a 2-bit saturating branch history counter.
//   cur   : current counter value
//   taken : resolved branch outcome
//   next  : counter moved one step toward the outcome, clamped at both ends
module sat_counter2
  import pipeline_pkg::*;
(
  input  ctr_e cur,
  input  logic taken,
  output ctr_e next
);

  always_comb begin
    next = cur;
    if (taken) begin
      if (cur != CTR_ST) next = ctr_e'(cur + 2'd1);
    end else begin
      if (cur != CTR_SNT) next = ctr_e'(cur - 2'd1);
    end
  end

endmodule

// File: rtl/branch_predictor.sv
// Direct-mapped dynamic branch predictor with BTB for beq in the IF stage.
//   clk, reset : rising-edge clock, asynchronous active-high reset
//   bus        : slave side of branch_predictor_if
//                fetch in (if_pc, if_ins) -> predict_taken / predict_target
//                resolve in (upd_*)       -> mispredict, table update, statistics
module branch_predictor
  import pipeline_pkg::*;
#(
  parameter int INDEX_BITS = 6,
  parameter int TAG_BITS   = 8,
  parameter int STAT_BITS  = 16
) (
  input logic clk,
  input logic reset,
  branch_predictor_if.slave bus
);

  localparam int ENTRIES = 1 << INDEX_BITS;
  localparam int TAG_HI  = INDEX_BITS + TAG_BITS + 1;

  logic [ENTRIES-1:0]   valid_q, valid_d;
  logic [TAG_BITS-1:0]  tag_q    [ENTRIES];
  logic [TAG_BITS-1:0]  tag_d    [ENTRIES];
  ctr_e                 ctr_q    [ENTRIES];
  ctr_e                 ctr_d    [ENTRIES];
  logic [31:0]          target_q [ENTRIES];
  logic [31:0]          target_d [ENTRIES];
  logic [STAT_BITS-1:0] stat_branches_q, stat_branches_d;
  logic [STAT_BITS-1:0] stat_mispredict_q, stat_mispredict_d;

  logic [INDEX_BITS-1:0] rd_idx, wr_idx;
  logic [TAG_BITS-1:0]   rd_tag, wr_tag;
  logic                  rd_hit, wr_hit, mispredict;
  ctr_e                  rd_ctr, wr_ctr_next;

  // PC bits outside index/tag and the instruction operand fields are not needed.
  logic unused_bits;
  assign unused_bits = ^{bus.if_pc[31:TAG_HI+1], bus.if_pc[1:0],
                         bus.upd_pc[31:TAG_HI+1], bus.upd_pc[1:0], bus.if_ins[25:0]};

  assign rd_idx = bus.if_pc[INDEX_BITS+1:2];
  assign rd_tag = bus.if_pc[TAG_HI:INDEX_BITS+2];
  assign wr_idx = bus.upd_pc[INDEX_BITS+1:2];
  assign wr_tag = bus.upd_pc[TAG_HI:INDEX_BITS+2];

  // Prediction reads the pre-edge table; same-cycle updates are not bypassed.
  assign rd_hit = valid_q[rd_idx] && (tag_q[rd_idx] == rd_tag);
  assign rd_ctr = ctr_q[rd_idx];
  assign wr_hit = valid_q[wr_idx] && (tag_q[wr_idx] == wr_tag);

  assign bus.predict_taken  = (bus.if_ins[31:26] == OPC_BEQ) && rd_hit && rd_ctr[1];
  assign bus.predict_target = rd_hit ? target_q[rd_idx] : 32'b0;

  assign mispredict          = bus.upd_valid && (bus.upd_taken != bus.upd_predicted);
  assign bus.mispredict      = mispredict;
  assign bus.stat_branches   = stat_branches_q;
  assign bus.stat_mispredict = stat_mispredict_q;

  sat_counter2 u_sat_counter2 (
    .cur   (ctr_q[wr_idx]),
    .taken (bus.upd_taken),
    .next  (wr_ctr_next)
  );

  // Table and statistics update; a not-taken miss leaves the table alone.
  always_comb begin
    valid_d           = valid_q;
    tag_d             = tag_q;
    ctr_d             = ctr_q;
    target_d          = target_q;
    stat_branches_d   = stat_branches_q;
    stat_mispredict_d = stat_mispredict_q;
    if (bus.upd_valid) begin
      if (wr_hit) begin
        ctr_d[wr_idx] = wr_ctr_next;
        if (bus.upd_taken) target_d[wr_idx] = bus.upd_target;
      end else if (bus.upd_taken) begin
        valid_d[wr_idx]  = 1'b1;
        tag_d[wr_idx]    = wr_tag;
        target_d[wr_idx] = bus.upd_target;
        ctr_d[wr_idx]    = CTR_WT;
      end
      if (stat_branches_q != '1)
        stat_branches_d = stat_branches_q + {{(STAT_BITS-1){1'b0}}, 1'b1};
      if (mispredict && (stat_mispredict_q != '1))
        stat_mispredict_d = stat_mispredict_q + {{(STAT_BITS-1){1'b0}}, 1'b1};
    end
  end

  // Flop arrays so the whole table clears asynchronously.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_q           <= '0;
      stat_branches_q   <= '0;
      stat_mispredict_q <= '0;
      for (int i = 0; i < ENTRIES; i++) begin
        tag_q[i]    <= '0;
        ctr_q[i]    <= CTR_WNT;
        target_q[i] <= '0;
      end
    end else begin
      valid_q           <= valid_d;
      tag_q             <= tag_d;
      ctr_q             <= ctr_d;
      target_q          <= target_d;
      stat_branches_q   <= stat_branches_d;
      stat_mispredict_q <= stat_mispredict_d;
    end
  end

endmodule

// File: tb/tb_branch_predictor.sv
// Self-checking bench for branch_predictor: directed vector table, a
// stats/reset sequence and randomized traffic against a reference model.
module tb_branch_predictor;
  import pipeline_pkg::*;

  localparam bit [31:0] BEQ = 32'h1000_0000;
  localparam bit [31:0] JMP = 32'h0800_0000;

  typedef struct {
    bit        uv;
    bit [31:0] upc;
    bit        ut;
    bit [31:0] utg;
    bit        up;
    bit [31:0] ipc;
    bit [31:0] ins;
    bit        e_taken;
    bit [31:0] e_target;
    bit        e_mp;
  } vec_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   failures = 0;

  int        m_valid [64];
  int        m_tag   [64];
  int        m_ctr   [64];
  bit [31:0] m_tgt   [64];
  int        m_br, m_mp;

  vec_t vecs [19];

  branch_predictor_if bus ();

  branch_predictor dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Reference model: table entries kept as plain integers.
  function automatic int pc_idx(bit [31:0] pc);
    return int'((pc >> 2) & 32'd63);
  endfunction

  function automatic int pc_tag(bit [31:0] pc);
    return int'((pc >> 8) & 32'd255);
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < 64; i++) begin
      m_valid[i] = 0;
      m_tag[i]   = 0;
      m_ctr[i]   = 1;
      m_tgt[i]   = 0;
    end
    m_br = 0;
    m_mp = 0;
  endfunction

  function automatic bit model_hit(bit [31:0] pc);
    return (m_valid[pc_idx(pc)] != 0) && (m_tag[pc_idx(pc)] == pc_tag(pc));
  endfunction

  function automatic bit model_taken();
    return ((bus.if_ins >> 26) == 32'd4) && model_hit(bus.if_pc) && (m_ctr[pc_idx(bus.if_pc)] >= 2);
  endfunction

  function automatic bit [31:0] model_target();
    return model_hit(bus.if_pc) ? m_tgt[pc_idx(bus.if_pc)] : 32'h0;
  endfunction

  function automatic bit model_mp();
    return bus.upd_valid && (bus.upd_taken != bus.upd_predicted);
  endfunction

  function automatic void model_update();
    int i;
    if (!bus.upd_valid) return;
    i = pc_idx(bus.upd_pc);
    if (model_mp() && m_mp < 65535) m_mp++;
    if (m_br < 65535) m_br++;
    if (model_hit(bus.upd_pc)) begin
      if (bus.upd_taken) begin
        if (m_ctr[i] < 3) m_ctr[i]++;
        m_tgt[i] = bus.upd_target;
      end else if (m_ctr[i] > 0) begin
        m_ctr[i]--;
      end
    end else if (bus.upd_taken) begin
      m_valid[i] = 1;
      m_tag[i]   = pc_tag(bus.upd_pc);
      m_tgt[i]   = bus.upd_target;
      m_ctr[i]   = 2;
    end
  endfunction

  // Compare one DUT value against an expected value.
  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_model(input string name);
    check_output({name, "/taken"}, 32'(bus.predict_taken), 32'(model_taken()));
    check_output({name, "/target"}, bus.predict_target, model_target());
    check_output({name, "/mispredict"}, 32'(bus.mispredict), 32'(model_mp()));
    check_output({name, "/stat_br"}, 32'(bus.stat_branches), 32'(m_br));
    check_output({name, "/stat_mp"}, 32'(bus.stat_mispredict), 32'(m_mp));
  endtask

  // Drive all inputs at the falling edge, then let combinational outputs settle.
  task automatic apply_stimulus(input bit uv, input bit [31:0] upc, input bit ut,
                                input bit [31:0] utg, input bit up,
                                input bit [31:0] ipc, input bit [31:0] ins);
    @(negedge clk);
    bus.upd_valid     = uv;
    bus.upd_pc        = upc;
    bus.upd_taken     = ut;
    bus.upd_target    = utg;
    bus.upd_predicted = up;
    bus.if_pc         = ipc;
    bus.if_ins        = ins;
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    bus.upd_valid = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    model_reset();
  endtask

  initial begin
    bus.if_pc = '0; bus.if_ins = '0; bus.upd_valid = 1'b0; bus.upd_pc = '0;
    bus.upd_taken = 1'b0; bus.upd_target = '0; bus.upd_predicted = 1'b0;
    model_reset();

    vecs[0]  = '{0, 32'h0,   0, 32'h0,   0, 32'h40,  BEQ, 0, 32'h0,   0};
    vecs[1]  = '{1, 32'h40,  1, 32'h80,  0, 32'h40,  BEQ, 0, 32'h0,   1};
    vecs[2]  = '{0, 32'h0,   0, 32'h0,   0, 32'h40,  BEQ, 1, 32'h80,  0};
    vecs[3]  = '{1, 32'h40,  1, 32'h80,  1, 32'h40,  BEQ, 1, 32'h80,  0};
    vecs[4]  = '{1, 32'h40,  1, 32'h80,  1, 32'h40,  BEQ, 1, 32'h80,  0};
    vecs[5]  = '{1, 32'h40,  0, 32'h0,   1, 32'h40,  BEQ, 1, 32'h80,  1};
    vecs[6]  = '{0, 32'h0,   0, 32'h0,   0, 32'h40,  BEQ, 1, 32'h80,  0};
    vecs[7]  = '{1, 32'h40,  0, 32'h0,   1, 32'h40,  BEQ, 1, 32'h80,  1};
    vecs[8]  = '{0, 32'h0,   0, 32'h0,   0, 32'h40,  BEQ, 0, 32'h80,  0};
    vecs[9]  = '{1, 32'h40,  1, 32'h84,  0, 32'h40,  BEQ, 0, 32'h80,  1};
    vecs[10] = '{1, 32'h40,  1, 32'h84,  1, 32'h40,  BEQ, 1, 32'h84,  0};
    vecs[11] = '{0, 32'h0,   0, 32'h0,   0, 32'h40,  JMP, 0, 32'h84,  0};
    vecs[12] = '{1, 32'h140, 1, 32'h200, 0, 32'h40,  BEQ, 1, 32'h84,  1};
    vecs[13] = '{0, 32'h0,   0, 32'h0,   0, 32'h40,  BEQ, 0, 32'h0,   0};
    vecs[14] = '{0, 32'h0,   0, 32'h0,   0, 32'h140, BEQ, 1, 32'h200, 0};
    vecs[15] = '{1, 32'h140, 0, 32'h0,   0, 32'h140, BEQ, 1, 32'h200, 0};
    vecs[16] = '{0, 32'h0,   0, 32'h0,   0, 32'h140, BEQ, 0, 32'h200, 0};
    vecs[17] = '{1, 32'h44,  0, 32'h0,   0, 32'h44,  BEQ, 0, 32'h0,   0};
    vecs[18] = '{0, 32'h0,   0, 32'h0,   0, 32'h44,  BEQ, 0, 32'h0,   0};

    repeat (2) @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < 19; i++) begin
      apply_stimulus(vecs[i].uv, vecs[i].upc, vecs[i].ut, vecs[i].utg, vecs[i].up,
                     vecs[i].ipc, vecs[i].ins);
      check_output($sformatf("vec%0d/taken", i), 32'(bus.predict_taken), 32'(vecs[i].e_taken));
      check_output($sformatf("vec%0d/target", i), bus.predict_target, vecs[i].e_target);
      check_output($sformatf("vec%0d/mispredict", i), 32'(bus.mispredict), 32'(vecs[i].e_mp));
      check_output($sformatf("vec%0d/stat_br", i), 32'(bus.stat_branches), 32'(m_br));
      check_output($sformatf("vec%0d/stat_mp", i), 32'(bus.stat_mispredict), 32'(m_mp));
      model_update();
    end

    // Five resolutions at 0x40, the first and last mispredicted.
    do_reset();
    apply_stimulus(1, 32'h40, 1, 32'h80, 0, 32'h40, BEQ); check_model("stats_u1"); model_update();
    apply_stimulus(1, 32'h40, 1, 32'h80, 1, 32'h40, BEQ); check_model("stats_u2"); model_update();
    apply_stimulus(1, 32'h40, 1, 32'h80, 1, 32'h40, BEQ); check_model("stats_u3"); model_update();
    apply_stimulus(1, 32'h40, 1, 32'h80, 1, 32'h40, BEQ); check_model("stats_u4"); model_update();
    apply_stimulus(1, 32'h40, 0, 32'h0,  1, 32'h40, BEQ); check_model("stats_u5"); model_update();
    apply_stimulus(0, 32'h0,  0, 32'h0,  0, 32'h40, BEQ);
    check_output("stats/branches", 32'(bus.stat_branches), 32'd5);
    check_output("stats/mispredicts", 32'(bus.stat_mispredict), 32'd2);
    check_output("stats/taken_before_reset", 32'(bus.predict_taken), 32'd1);
    #2 reset = 1'b1;
    #1;
    check_output("async_reset/branches", 32'(bus.stat_branches), 32'd0);
    check_output("async_reset/mispredicts", 32'(bus.stat_mispredict), 32'd0);
    check_output("async_reset/taken", 32'(bus.predict_taken), 32'd0);
    check_output("async_reset/target", bus.predict_target, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    model_reset();
    apply_stimulus(0, 32'h0, 0, 32'h0, 0, 32'h40, BEQ);
    check_model("after_reset");

    // Random traffic over a few indices and tags so hits, conflicts and aliasing all occur.
    for (int n = 0; n < 3000; n++) begin
      bit [31:0] r_hi, ipc, upc, ins;
      r_hi = $urandom;
      ipc  = {r_hi[15:0], 8'($urandom_range(0, 2)), 6'($urandom_range(0, 3)), 2'b00};
      r_hi = $urandom;
      upc  = {r_hi[15:0], 8'($urandom_range(0, 2)), 6'($urandom_range(0, 3)), 2'b00};
      ins  = ($urandom_range(0, 3) != 0) ? (BEQ | ($urandom & 32'h03ff_ffff)) : $urandom;
      apply_stimulus($urandom_range(0, 3) != 0, upc, 1'($urandom_range(0, 1)),
                     $urandom & 32'hffff_fffc, 1'($urandom_range(0, 1)), ipc, ins);
      check_model($sformatf("rand%0d", n));
      model_update();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
